sketch_rmw_updater: RTL
=======================

// Module: sketch_rmw_updater
// PURPOSE
//  Read-modify-write front end for one sketch counter array held in dual_port_ram.
//  - Accepts (bucket address, increment) updates at one per cycle.
//  - Reads the counter on RAM port A and writes the sum back on RAM port B.
//  - Forwards values around the 1-cycle read latency.
//  - Zero-sweeps the whole array after reset and on request.
// PARAMETERS
//  DPW    10  RAM address width; array depth is 2**DPW
//  DW     64  counter width; must match the RAM DW
//  INC_W  16  increment width, zero-extended to DW
// PORTS
//  clk        in   1      single clock; drives both RAM clocks (clka = clkb = clk)
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      update request valid
//  in_ready   out  1      update accepted when in_valid & in_ready
//  in_addr    in   DPW    bucket index
//  in_inc     in   INC_W  increment, unsigned
//  clear_req  in   1      1-cycle pulse: zero the whole array
//  clear_busy out  1      high while DRAIN or CLEAR
//  ram_wea    out  1      tied to 0; port A is read-only
//  ram_addra  out  DPW    = in_addr, combinational
//  ram_dina   out  DW     tied to 0
//  ram_douta  in   DW     registered read data, valid 1 cycle after address
//  ram_web    out  1      port B write enable
//  ram_addrb  out  DPW    port B write address
//  ram_dinb   out  DW     port B write data
//  upd_cnt    out  32     completed updates since last reset or clear; wraps at 2**32
// BEHAVIOUR
//  - FSM states:
//    - CLEAR: in_ready=0. ram_web=1, ram_addrb=clr_ptr, ram_dinb=0; clr_ptr increments.
//      When clr_ptr == 2**DPW-1 is written, go to RUN. Lasts exactly 2**DPW cycles.
//    - RUN: in_ready=1. clear_req=1 goes to DRAIN.
//    - DRAIN: in_ready=0 for exactly 1 cycle, while any S1 write retires; then CLEAR.
//  - Reset state is CLEAR. Reset values:
//    - clr_ptr=0, upd_cnt=0, S1 valid=0, forward valid=0.
//    - clear_busy=1, in_ready=0, ram_web=0, ram_addrb=0, ram_dinb=0 until the first clk edge.
//  - clear_req is ignored in DRAIN and CLEAR. Entering CLEAR zeroes upd_cnt.
//  - Pipeline:
//    - Cycle t (accept): in_addr is presented on ram_addra. S1 registers {addr, inc} with s1_v=1.
//    - Cycle t+1: base = fwd hit ? fwd_data : ram_douta; sum = base + inc.
//      ram_web=1, ram_addrb=s1_addr, ram_dinb=sum, combinational from ram_douta.
//    - Write latency is 1 cycle from accept. Sustained throughput is 1 update per cycle.
//  - Forwarding:
//    - Register {fwd_v, fwd_addr, fwd_data} captures every port B write, including CLEAR writes.
//    - fwd hit = fwd_v & (fwd_addr == s1_addr).
//    - Covers the back-to-back same-address case, where the port A read races the port B write
//      of the previous cycle and returns stale data.
//    - Only one-deep forwarding is needed. A gap of 2 or more cycles reads committed data.
//  - Outside active write cycles: ram_web=0; ram_addrb and ram_dinb hold their last values.
//  - Async reset mid-update: the in-flight S1 write is dropped and not retried.
//    The array is then re-zeroed by CLEAR.
// CONFIGURATION
//  - SKETCH_RMW_SAT_EN defined: sum = min(base + inc, 2**DW-1). A saturated counter stays
//    at all-ones.
//  - SKETCH_RMW_SAT_EN undefined: sum = (base + inc) mod 2**DW; wraps silently.
// TESTING
//  1. Reset, then hold in_valid=0.
//     -> clear_busy=1 for 1024 cycles (DPW=10), ram_web=1 sweeping addr 0..1023 with data 0,
//        then in_ready=1.
//  2. Single update addr=5, inc=3, after clear.
//     -> next cycle ram_web=1, ram_addrb=5, ram_dinb=3; upd_cnt=1.
//  3. Back-to-back addr=7 with inc=1,2,3 on consecutive cycles.
//     -> writes 1, 3, 6; mem[7]=6, which proves forwarding.
//  4. Interleave addr=7 inc=4, then addr=9 inc=1, then addr=7 inc=4.
//     -> mem[7]=8, mem[9]=1, read via the non-forwarded path.
//  5. Preload mem[3]=2**DW-2, then update addr=3 inc=5.
//     -> SAT_EN: mem[3]=2**DW-1; without it: mem[3]=3.
//  6. clear_req during a stream.
//     -> the accepted op retires in DRAIN, in_ready=0 for 1+1024 cycles, all entries 0,
//        upd_cnt=0; assert rst_n=0 mid-CLEAR -> clr_ptr restarts at 0.

Source files
------------

// File: rtl/sketch_rmw_updater.sv
// sketch_rmw_updater: read-modify-write front end for one sketch counter array
// held in a dual-port RAM. Port A reads the bucket, port B writes back the sum
// one cycle later. A one-deep forwarding register covers the back-to-back
// same-bucket case. The whole array is zero-swept after reset and on request.
//
// Optional build macro:
//   SKETCH_RMW_SAT_EN  counters saturate at all-ones instead of wrapping.
//
// Ports:
//   clk, rst_n             single clock (both RAM ports), async active-low reset
//   in_valid/in_ready      update handshake; in_addr bucket, in_inc increment
//   clear_req              1-cycle pulse requesting a full-array zero sweep
//   clear_busy             high while draining or sweeping
//   ram_wea/addra/dina     RAM port A (read-only, address = in_addr)
//   ram_douta              RAM port A registered read data
//   ram_web/addrb/dinb     RAM port B write
//   upd_cnt                completed updates since reset or last clear
module sketch_rmw_updater #(
    parameter int unsigned DPW   = 10,
    parameter int unsigned DW    = 64,
    parameter int unsigned INC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DPW-1:0]   in_addr,
    input  logic [INC_W-1:0] in_inc,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             ram_wea,
    output logic [DPW-1:0]   ram_addra,
    output logic [DW-1:0]    ram_dina,
    input  logic [DW-1:0]    ram_douta,
    output logic             ram_web,
    output logic [DPW-1:0]   ram_addrb,
    output logic [DW-1:0]    ram_dinb,
    output logic [31:0]      upd_cnt
);

    localparam logic [DPW-1:0] CLR_LAST = {DPW{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              clr_arm;
    logic [DPW-1:0]    clr_ptr;
    logic              clr_adv;
    logic              s1_v;
    logic [DPW-1:0]    s1_addr;
    logic [INC_W-1:0]  s1_inc;
    logic              fwd_v;
    logic [DPW-1:0]    fwd_addr;
    logic [DW-1:0]     fwd_data;
    logic              fwd_hit;
    logic [DW-1:0]     base;
    logic [DW-1:0]     sum;
    logic              accept;
    logic              enter_clear;

    // Port A is a pure read port driven straight from the request.
    assign ram_wea   = 1'b0;
    assign ram_dina  = '0;
    assign ram_addra = in_addr;

    assign accept      = in_valid & in_ready;
    assign enter_clear = (state != ST_CLEAR) && (state_nxt == ST_CLEAR);

    // Last port B write wins over the RAM read, which is stale when the
    // previous cycle wrote the same bucket.
    assign fwd_hit = fwd_v && (fwd_addr == s1_addr);
    assign base    = fwd_hit ? fwd_data : ram_douta;

`ifdef SKETCH_RMW_SAT_EN
    logic [DW:0] sum_ext;
    assign sum_ext = {1'b0, base} + (DW+1)'(s1_inc);
    assign sum     = sum_ext[DW] ? {DW{1'b1}} : sum_ext[DW-1:0];
`else
    assign sum = base + DW'(s1_inc);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and port B / handshake decode. Port B address and data fall
    // back to the forwarding register, which equals the last write issued.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        clear_busy = 1'b1;
        ram_web    = 1'b0;
        ram_addrb  = fwd_addr;
        ram_dinb   = fwd_data;
        clr_adv    = 1'b0;
        case (state)
            ST_CLEAR: begin
                // clr_arm keeps port B quiet between reset release and the first edge.
                if (clr_arm) begin
                    ram_web   = 1'b1;
                    ram_addrb = clr_ptr;
                    ram_dinb  = '0;
                    clr_adv   = 1'b1;
                    if (clr_ptr == CLR_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                in_ready   = 1'b1;
                clear_busy = 1'b0;
                if (s1_v) begin
                    ram_web   = 1'b1;
                    ram_addrb = s1_addr;
                    ram_dinb  = sum;
                end
                if (clear_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Retire the op accepted alongside clear_req, then sweep.
                if (s1_v) begin
                    ram_web   = 1'b1;
                    ram_addrb = s1_addr;
                    ram_dinb  = sum;
                end
                state_nxt = ST_CLEAR;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Sweep pointer; restarts at zero on every entry into the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_arm <= 1'b0;
            clr_ptr <= '0;
        end else begin
            clr_arm <= 1'b1;
            if (enter_clear) begin
                clr_ptr <= '0;
            end else if (clr_adv) begin
                clr_ptr <= clr_ptr + DPW'(1);
            end
        end
    end

    // Stage 1: accepted request waiting for its read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_addr <= '0;
            s1_inc  <= '0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_addr <= in_addr;
                s1_inc  <= in_inc;
            end
        end
    end

    // Forwarding register: captures every port B write, sweep writes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_v    <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else if (ram_web) begin
            fwd_v    <= 1'b1;
            fwd_addr <= ram_addrb;
            fwd_data <= ram_dinb;
        end
    end

    // Completed-update counter; an update completes in its write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt <= '0;
        end else if (enter_clear) begin
            upd_cnt <= '0;
        end else if (s1_v) begin
            upd_cnt <= upd_cnt + 32'd1;
        end
    end

endmodule
